hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Parametrised hazard detection and stall sequencer for the 5-stage MIPS pipeline; successor to the single-cycle load-use detector. Sits beside the ID stage: compares ID source registers against EX/MEM destinations and generates PC/IF-ID hold and ID/EX bubble controls. Adds multi-cycle load-use stalls for slow data memory, optional branch-in-ID operand hazards, flush override and a saturating stall-cycle counter.

## Interface

- REG_ADDR_W, 5, register address width
- LOAD_STALL, 1, total stall cycles per load-use hazard (1..15)
- BRANCH_IN_ID, 1, 1 = enable branch operand hazard detection in ID
- CNT_W, 16, stall counter width

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst_n  in  1  asynchronous active-low reset
- ID_Valid  in  1  ID holds a real instruction
- ID_Rs, ID_Rt  in  REG_ADDR_W  ID source registers
- ID_UsesRs, ID_UsesRt  in  1  instruction actually reads Rs/Rt
- ID_IsBranch  in  1  ID instruction is a branch resolved in ID
- EX_RegWrite, EX_MemRead  in  1  EX instruction writes a register / is a load
- EX_WriteReg  in  REG_ADDR_W  EX destination register
- MEM_MemRead  in  1  MEM instruction is a load
- MEM_WriteReg  in  REG_ADDR_W  MEM destination register
- Flush  in  1  ID instruction is being killed (taken branch/jump)
- CntClr  in  1  synchronous clear of StallCycles
- Stall  out  1  hold PC and IF/ID
- Bubble  out  1  zero controls into ID/EX
- StallCycles  out  CNT_W  saturating count of stalled cycles

## Operation

- Match(X) = ID_Valid && X != 0 && ((ID_UsesRs && X == ID_Rs) || (ID_UsesRt && X == ID_Rt)).
- LoadUse = EX_MemRead && Match(EX_WriteReg).
- BranchHaz = BRANCH_IN_ID && ID_IsBranch && ((EX_RegWrite && Match(EX_WriteReg)) || (MEM_MemRead && Match(MEM_WriteReg))).
- Register 0 never causes a hazard.
- States: IDLE, HOLD; 4-bit remaining counter Rem.
- IDLE: Stall = Bubble = LoadUse || BranchHaz (combinational). If LoadUse && LOAD_STALL > 1 && !Flush: go HOLD, Rem = LOAD_STALL-1. Else stay IDLE.
- HOLD: Stall = Bubble = 1 regardless of hazard inputs. Rem decrements each cycle; when Rem == 1 at a clock edge, go IDLE. Total stall per load-use = LOAD_STALL cycles.
- After HOLD returns to IDLE, hazards re-evaluated normally (branch may stall further on MEM load).
- Flush = 1 in any state: Stall = Bubble = 0 that cycle; next state IDLE, Rem = 0. Flush has priority over all hazards.
- StallCycles: +1 each cycle Stall = 1; holds at 2^CNT_W-1; CntClr forces 0 next edge (CntClr wins over increment).

## Timing

- Reset (Rst_n low, asynchronous): state IDLE, Rem 0, StallCycles 0; Stall and Bubble forced 0 while Rst_n low.
- Detection latency 0 cycles (same cycle as inputs); HOLD extension begins next edge.
- LOAD_STALL = 1: identical to classic one-bubble load-use; HOLD never entered.
- Reset deasserted mid-HOLD sequence: sequence abandoned, restart in IDLE.
- Counter update and state transition occur on same rising edge.

## Test plan

- LOAD_STALL=1: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8, ID_UsesRs=1 -> Stall=Bubble=1 one cycle, StallCycles=1, state stays IDLE.
- LOAD_STALL=3, same hazard held one cycle then EX inputs cleared -> Stall=1 for exactly 3 consecutive cycles, StallCycles=3.
- EX_WriteReg=0 with ID_Rs=0 load, or ID_UsesRt=0 with ID_Rt match -> Stall=0.
- BRANCH_IN_ID=1: ID_IsBranch=1, EX_RegWrite=1, EX_WriteReg=5, ID_Rt=5 -> Stall=1; next cycle MEM_MemRead=1, MEM_WriteReg=5 -> Stall=1; with BRANCH_IN_ID=0 -> Stall=0 both cycles.
- LOAD_STALL=4, Flush=1 on second stall cycle -> Stall=0 that cycle, state IDLE next edge, StallCycles=1.
- Rst_n pulsed low during HOLD -> Stall, Bubble, StallCycles = 0 immediately; counter saturates at 65535 with CNT_W=16 after forced long stall, CntClr -> 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_stall_ctrl : ID-stage load-use / branch-operand hazard detection with
//                     multi-cycle load stall sequencing and stall counter
// Revision 1.0
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_STALL   = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_IsBranch,
  input  logic                  EX_RegWrite,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_WriteReg,
  input  logic                  MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
  input  logic                  Flush,
  input  logic                  CntClr,
  output logic                  Stall,
  output logic                  Bubble,
  output logic [CNT_W-1:0]      StallCycles
);

  localparam bit       MULTI_STALL = (LOAD_STALL > 1);
  localparam bit       BR_EN       = (BRANCH_IN_ID != 0);
  localparam logic [3:0] HOLD_INIT = 4'(LOAD_STALL - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_match, mem_match, load_use, branch_haz, stall_w;

  // Register 0 is hard-wired zero, so a write to it can never create a dependency.
  assign ex_match  = ID_Valid && (EX_WriteReg != '0) &&
                     ((ID_UsesRs && (EX_WriteReg == ID_Rs)) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
  assign mem_match = ID_Valid && (MEM_WriteReg != '0) &&
                     ((ID_UsesRs && (MEM_WriteReg == ID_Rs)) || (ID_UsesRt && (MEM_WriteReg == ID_Rt)));

  assign load_use   = EX_MemRead && ex_match;
  assign branch_haz = BR_EN && ID_IsBranch &&
                      ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_w = 1'b0;
    if (Flush) begin
      state_d = IDLE;
      rem_d   = 4'd0;
    end else if (state_q == HOLD) begin
      stall_w = 1'b1;
      rem_d   = rem_q - 4'd1;
      if (rem_q == 4'd1) begin
        state_d = IDLE;
      end
    end else begin
      stall_w = load_use || branch_haz;
      rem_d   = 4'd0;
      if (load_use && MULTI_STALL) begin
        state_d = HOLD;
        rem_d   = HOLD_INIT;
      end
    end
  end

  assign Stall  = Rst_n && stall_w;
  assign Bubble = Stall;

  always_comb begin
    cnt_d = cnt_q;
    if (CntClr) begin
      cnt_d = '0;
    end else if (Stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallCycles = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_ctrl : three parameterisations driven in lockstep against a
//                        behavioural reference with a scoreboard queue
// Revision 1.0
// ============================================================================
module tb_hazard_stall_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       ID_Valid, ID_UsesRs, ID_UsesRt, ID_IsBranch;
  logic [4:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic       EX_RegWrite, EX_MemRead, MEM_MemRead, Flush, CntClr;
  logic       stall_o [3];
  logic       bubble_o[3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  always #5 Clk = ~Clk;

  // k0: LOAD_STALL=1 branch on; k1: LOAD_STALL=3 branch off; k2: LOAD_STALL=4, 4-bit counter
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .BRANCH_IN_ID(1), .CNT_W(16)) u_k0 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .Flush(Flush), .CntClr(CntClr),
    .Stall(stall_o[0]), .Bubble(bubble_o[0]), .StallCycles(cnt0));
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .BRANCH_IN_ID(0), .CNT_W(16)) u_k1 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .Flush(Flush), .CntClr(CntClr),
    .Stall(stall_o[1]), .Bubble(bubble_o[1]), .StallCycles(cnt1));
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(4), .BRANCH_IN_ID(1), .CNT_W(4)) u_k2 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .Flush(Flush), .CntClr(CntClr),
    .Stall(stall_o[2]), .Bubble(bubble_o[2]), .StallCycles(cnt2));

  typedef struct {
    int   k;
    logic stall;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   LS[3]   = '{1, 3, 4};
  int   BR[3]   = '{1, 0, 1};
  int   CMAX[3] = '{65535, 65535, 15};
  int   m_st[3], m_rem[3], m_cnt[3], n_st[3], n_rem[3], n_cnt[3];

  function automatic logic [31:0] act_cnt(input int k);
    if (k == 0) return {16'd0, cnt0};
    if (k == 1) return {16'd0, cnt1};
    return {28'd0, cnt2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic mt(input logic [4:0] x);
    return ID_Valid && (x != 5'd0) &&
           ((ID_UsesRs && (x == ID_Rs)) || (ID_UsesRt && (x == ID_Rt)));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_rem[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Reference behaviour for the current inputs; expected outputs go to the scoreboard.
  task automatic eval_push();
    for (int k = 0; k < 3; k++) begin
      logic lu, bh, s;
      lu = EX_MemRead && mt(EX_WriteReg);
      bh = (BR[k] != 0) && ID_IsBranch &&
           ((EX_RegWrite && mt(EX_WriteReg)) || (MEM_MemRead && mt(MEM_WriteReg)));
      n_st[k] = m_st[k]; n_rem[k] = m_rem[k];
      if (Flush) begin
        s = 1'b0; n_st[k] = 0; n_rem[k] = 0;
      end else if (m_st[k] == 1) begin
        s = 1'b1; n_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 1) n_st[k] = 0;
      end else begin
        s = lu || bh;
        if (lu && LS[k] > 1) begin
          n_st[k] = 1; n_rem[k] = LS[k] - 1;
        end
      end
      if (CntClr) n_cnt[k] = 0;
      else if (s && m_cnt[k] < CMAX[k]) n_cnt[k] = m_cnt[k] + 1;
      else n_cnt[k] = m_cnt[k];
      sb.push_back('{k, s, m_cnt[k]});
    end
  endtask

  task automatic cyc();
    exp_t e;
    eval_push();
    @(negedge Clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("stall_k%0d", e.k),  {31'd0, stall_o[e.k]},  {31'd0, e.stall});
      chk($sformatf("bubble_k%0d", e.k), {31'd0, bubble_o[e.k]}, {31'd0, e.stall});
      chk($sformatf("cnt_k%0d", e.k),    act_cnt(e.k),           e.cnt);
    end
    @(posedge Clk);
    for (int k = 0; k < 3; k++) begin
      m_st[k] = n_st[k]; m_rem[k] = n_rem[k]; m_cnt[k] = n_cnt[k];
    end
    #1;
  endtask

  task automatic clr_in();
    ID_Valid = 1'b1; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_IsBranch = 1'b0;
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_WriteReg = 5'd0; MEM_WriteReg = 5'd0;
    EX_RegWrite = 1'b0; EX_MemRead = 1'b0; MEM_MemRead = 1'b0; Flush = 1'b0; CntClr = 1'b0;
  endtask

  task automatic load_use8();
    ID_UsesRs = 1'b1; ID_Rs = 5'd8; EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
  endtask

  initial begin
    clr_in();
    Rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_stall_k%0d", k), {31'd0, stall_o[k]}, 32'd0);
      chk($sformatf("rst_cnt_k%0d", k), act_cnt(k), 32'd0);
    end
    Rst_n = 1'b1;

    // Load-use held one cycle, then EX cleared: stall lengths 1, 3 and 4
    load_use8();
    cyc();
    EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
    repeat (4) cyc();
    chk("lu_total_k0", act_cnt(0), 32'd1);
    chk("lu_total_k1", act_cnt(1), 32'd3);
    chk("lu_total_k2", act_cnt(2), 32'd4);
    CntClr = 1'b1; cyc(); CntClr = 1'b0;

    // Register 0 and unused-operand matches never stall
    ID_UsesRs = 1'b1; ID_Rs = 5'd0; EX_MemRead = 1'b1; EX_WriteReg = 5'd0;
    cyc();
    ID_UsesRs = 1'b0; ID_Rs = 5'd3; ID_UsesRt = 1'b0; ID_Rt = 5'd9; EX_WriteReg = 5'd9;
    cyc();

    // Branch operand hazards: EX ALU result, then MEM load, then MEM non-load
    clr_in();
    ID_IsBranch = 1'b1; ID_UsesRt = 1'b1; ID_Rt = 5'd5; EX_RegWrite = 1'b1; EX_WriteReg = 5'd5;
    cyc();
    EX_RegWrite = 1'b0; EX_WriteReg = 5'd0; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd5;
    cyc();
    MEM_MemRead = 1'b0;
    cyc();

    // Flush on the second stall cycle kills the sequence
    clr_in();
    CntClr = 1'b1; cyc(); CntClr = 1'b0;
    load_use8();
    cyc();
    EX_MemRead = 1'b0; EX_WriteReg = 5'd0; Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    cyc();
    chk("flush_cnt_k2", act_cnt(2), 32'd1);
    load_use8(); Flush = 1'b1;
    cyc();
    clr_in();
    cyc();

    // Asynchronous reset mid-HOLD abandons the sequence
    load_use8();
    cyc();
    EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
    cyc();
    load_use8();
    #2 Rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_stall_k%0d", k), {31'd0, stall_o[k]}, 32'd0);
      chk($sformatf("arst_bubble_k%0d", k), {31'd0, bubble_o[k]}, 32'd0);
      chk($sformatf("arst_cnt_k%0d", k), act_cnt(k), 32'd0);
    end
    clr_in();
    model_reset();
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    cyc();

    // Sustained hazard saturates the 4-bit counter; clear wins over increment
    load_use8();
    repeat (20) cyc();
    chk("sat_cnt_k2", act_cnt(2), 32'd15);
    CntClr = 1'b1;
    cyc();
    CntClr = 1'b0;
    clr_in();
    cyc();
    chk("clr_cnt_k0", act_cnt(0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
